// File: rtl/press_trigger_pkg.sv
// rtl/press_trigger_pkg.sv - shared debounce encodings and timing defaults for the press trigger path
package press_trigger_pkg;

   localparam logic [1:0] ST_IDLE_LOW  = 2'd0;
   localparam logic [1:0] ST_WAIT_HIGH = 2'd1;
   localparam logic [1:0] ST_IDLE_HIGH = 2'd2;
   localparam logic [1:0] ST_WAIT_LOW  = 2'd3;

   typedef enum logic [1:0] {
      IDLE_LOW  = ST_IDLE_LOW,
      WAIT_HIGH = ST_WAIT_HIGH,
      IDLE_HIGH = ST_IDLE_HIGH,
      WAIT_LOW  = ST_WAIT_LOW
   } deb_state_t;

   // Tick rate and lockout hold length are kept together so the hold time is set in one place.
   localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;
   localparam int DEFAULT_TICK_DIV        = 100000;
   localparam int LOCK_HOLD_TICKS         = 1000;

endpackage

// File: rtl/press_trigger_debounce.sv
// rtl/press_trigger_debounce.sv - two-flop synchroniser plus debounce FSM
// press is a single-cycle strobe on the edge where a debounced press is accepted.
module sync_debounce
   import press_trigger_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic btn_level,
   output logic press
);

   localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          s1, s2;
   deb_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1        <= 1'b0;
         s2        <= 1'b0;
         state_q   <= IDLE_LOW;
         cnt_q     <= '0;
         btn_level <= 1'b0;
      end else begin
         s1        <= btn_raw;
         s2        <= s1;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         btn_level <= level_d;
      end
   end

   // Any sample disagreeing with the pending level sends the FSM back to idle with a cleared count.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = btn_level;
      press   = 1'b0;
      unique case (state_q)
         IDLE_LOW: begin
            if (s2) begin
               state_d = WAIT_HIGH;
               cnt_d   = CW'(1);
            end
         end
         WAIT_HIGH: begin
            if (!s2) begin
               state_d = IDLE_LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE_HIGH;
               cnt_d   = '0;
               level_d = 1'b1;
               press   = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         IDLE_HIGH: begin
            if (!s2) begin
               state_d = WAIT_LOW;
               cnt_d   = CW'(1);
            end
         end
         WAIT_LOW: begin
            if (s2) begin
               state_d = IDLE_HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE_LOW;
               cnt_d   = '0;
               level_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
      endcase
   end

endmodule

// File: rtl/press_trigger.sv
// rtl/press_trigger.sv - button conditioning and tick strobe feeding the lockout block
// trig/dropped split a debounced press by lock_active; tick is a free-running divider.
module press_trigger
   import press_trigger_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int TICK_DIV        = DEFAULT_TICK_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   input  logic lock_active,
   output logic trig,
   output logic tick,
   output logic btn_level,
   output logic dropped
);

   localparam int            TW        = $clog2(TICK_DIV);
   localparam logic [TW-1:0] TCNT_LAST = TW'(TICK_DIV - 1);

   logic          press;
   logic [TW-1:0] tcnt;

   sync_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (btn_raw),
      .btn_level (btn_level),
      .press     (press)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         trig    <= 1'b0;
         dropped <= 1'b0;
      end else begin
         trig    <= press & ~lock_active;
         dropped <= press & lock_active;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tcnt <= '0;
         tick <= 1'b0;
      end else if (tcnt == TCNT_LAST) begin
         tcnt <= '0;
         tick <= 1'b1;
      end else begin
         tcnt <= tcnt + TW'(1);
         tick <= 1'b0;
      end
   end

endmodule

// File: tb/tb_press_trigger.sv
// tb/tb_press_trigger.sv - directed self-checking bench for press_trigger (D=4, TICK_DIV=5)
module tb_press_trigger;

   logic clk = 1'b0;
   logic rst, btn_raw, lock_active;
   logic trig, tick, btn_level, dropped;

   int vectors = 0;
   int miscompares = 0;
   int n_post = 0;

   always #5 clk = ~clk;

   press_trigger #(
      .DEBOUNCE_CYCLES(4),
      .TICK_DIV(5)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_raw     (btn_raw),
      .lock_active (lock_active),
      .trig        (trig),
      .tick        (tick),
      .btn_level   (btn_level),
      .dropped     (dropped)
   );

   task automatic check(input string tag, input logic observed, input logic expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("FAIL %s observed=%b expected=%b at %0t", tag, observed, expected, $time);
      end
   endtask

   // Advance one edge and check tick against the count of post-reset edges.
   task automatic step();
      @(posedge clk);
      #1;
      if (rst) n_post = 0;
      else n_post++;
      check("tick", tick, (n_post > 0) && (n_post % 5 == 0));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".trig"}, trig, 1'b0);
      check({tag, ".dropped"}, dropped, 1'b0);
      check({tag, ".btn_level"}, btn_level, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      btn_raw = 1'b0;
      lock_active = 1'b0;

      for (int k = 0; k < 3; k++) begin
         step();
         check_all_zero("reset");
      end
      rst = 1'b0;

      // Clean press held 20 cycles
      btn_raw = 1'b1;
      for (int k = 0; k < 20; k++) begin
         step();
         check("clean.trig", trig, k == 5);
         check("clean.dropped", dropped, 1'b0);
         check("clean.btn_level", btn_level, k >= 5);
      end

      btn_raw = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         check("rel1.btn_level", btn_level, k < 5);
         check("rel1.trig", trig, 1'b0);
         check("rel1.dropped", dropped, 1'b0);
      end

      // Press while lock is active
      lock_active = 1'b1;
      btn_raw = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step();
         check("locked.dropped", dropped, k == 5);
         check("locked.trig", trig, 1'b0);
         check("locked.btn_level", btn_level, k >= 5);
      end

      lock_active = 1'b0;
      btn_raw = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         check("rel2.btn_level", btn_level, k < 5);
         check("rel2.trig", trig, 1'b0);
         check("rel2.dropped", dropped, 1'b0);
      end

      // Bounce 1,0,1,0 then hold: last rise sampled at k=4, trig after k=9
      for (int k = 0; k < 16; k++) begin
         btn_raw = (k < 4) ? ((k % 2) == 0) : 1'b1;
         step();
         check("bounce.trig", trig, k == 9);
         check("bounce.dropped", dropped, 1'b0);
         check("bounce.btn_level", btn_level, k >= 9);
      end

      btn_raw = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         check("rel3.btn_level", btn_level, k < 5);
         check("rel3.trig", trig, 1'b0);
      end

      // Reset arriving at edge 2 of a held press
      btn_raw = 1'b1;
      for (int k = 0; k < 2; k++) begin
         step();
         check("mid.trig", trig, 1'b0);
      end
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         step();
         check_all_zero("midrst");
      end
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         check("after_rst.trig", trig, k == 5);
         check("after_rst.dropped", dropped, 1'b0);
         check("after_rst.btn_level", btn_level, k >= 5);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/press_trigger.md
# press_trigger

Upstream conditioning stage for the lockout block: turns a raw asynchronous push-button into a clean one-cycle `trig` pulse and generates the periodic `tick` strobe that the lockout block counts. It synchronises and debounces the button, issues a trigger only on a debounced press, and suppresses (and flags) presses that arrive while the downstream lock is already active. All outputs are registered, glitch-free pulses, safe to use as edge sources downstream.

## Interface
- `DEBOUNCE_CYCLES`, 250000: consecutive stable cycles required to accept a level change; must be ≥ 2.
- `TICK_DIV`, 100000: `tick` period in clock cycles; must be ≥ 2.
- `clk` in 1: the single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `btn_raw` in 1: raw button, asynchronous, bouncing.
- `lock_active` in 1: downstream lock status (`enableLock`), synchronous to `clk`.
- `trig` out 1: one-cycle pulse on an accepted debounced press.
- `tick` out 1: one-cycle pulse every `TICK_DIV` cycles.
- `btn_level` out 1: debounced button level.
- `dropped` out 1: one-cycle pulse on a debounced press rejected because `lock_active` = 1.

## Operation
- Synchroniser: two flops, `s1 <= btn_raw`, `s2 <= s1`. Only `s2` is used downstream.
- Debounce FSM states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW. Counter `cnt` is `$clog2(DEBOUNCE_CYCLES)` bits wide.
- IDLE_LOW: if `s2` = 1, go to WAIT_HIGH with `cnt` = 1.
- WAIT_HIGH: if `s2` = 0, go to IDLE_LOW with `cnt` = 0 (a glitch fully restarts the count). Otherwise, if `cnt` = DEBOUNCE_CYCLES−1, go to IDLE_HIGH, set `btn_level` = 1 and fire the press event. Otherwise increment `cnt`.
- IDLE_HIGH and WAIT_LOW mirror the above for release. Release sets `btn_level` = 0 and fires no event.
- Press event, using `lock_active` sampled at the same edge:
  - `lock_active` = 0: `trig` <= 1.
  - `lock_active` = 1: `dropped` <= 1.
  - Never both. Both pulses self-clear the next cycle.
- At most one `trig` per debounced press, however long the button is held.
- Tick generator: `tcnt` is `$clog2(TICK_DIV)` bits wide and free-running 0..TICK_DIV−1. It wraps to 0 and sets `tick` <= 1 on the edge where `tcnt` = TICK_DIV−1. It is independent of the button path and of `lock_active`.

## Timing
- Reset values:
  - `trig`, `tick`, `dropped`, `btn_level` = 0.
  - `s1`, `s2` = 0; state = IDLE_LOW; `cnt` = 0; `tcnt` = 0.
- Press latency: call the first edge that samples `btn_raw` = 1 edge 0. With the input clean, `trig` is high for exactly the cycle after edge DEBOUNCE_CYCLES+1.
- Release latency: `btn_level` falls after the same DEBOUNCE_CYCLES+1 edges.
- First `tick` after reset is high in the cycle after the TICK_DIV-th post-reset edge. It repeats every TICK_DIV cycles exactly.
- `tick` and `trig` may be high in the same cycle; neither affects the other.
- Reset mid-operation clears all state, including an in-progress debounce and a pending pulse. A button still held after reset is re-debounced from IDLE_LOW and produces a fresh `trig`/`dropped`.
- A change in `lock_active` only affects a press event whose transition edge samples it.

## Structure
- Shared package/include holds:
  - debounce state encodings (2-bit localparams);
  - default `DEBOUNCE_CYCLES` and `TICK_DIV`, so the lockout hold time (1000 ticks) and tick rate live in one place.
- One sub-module, `sync_debounce`, containing the synchroniser, FSM and `cnt`. It outputs `btn_level` and a one-cycle `press` strobe.
- The top level adds the `lock_active` gating, the `trig`/`dropped` registers and the tick generator.

## Test plan
- Reset check, DEBOUNCE_CYCLES=4, TICK_DIV=5: assert `rst` for 3 cycles → all outputs 0 during reset. First `tick` is in the cycle after post-reset edge 5, then every 5 cycles.
- Clean press, D=4, `lock_active`=0: `btn_raw` rises before edge 0 and is held 20 cycles → `trig` high only in the cycle after edge 5, `btn_level` 1 from then on, no second `trig`.
- Bounce, D=4: `btn_raw` toggles 1,0,1,0 on successive edges, then holds 1 → no `trig` during the bounce. A single `trig` follows 6 edges after the final rise is first sampled.
- Locked press: `lock_active`=1 throughout a clean press → `dropped` pulses once in the cycle `trig` would have; `trig` stays 0.
- Release, then re-press with `lock_active`=0 → `btn_level` falls after 5 edges with no pulse. The second press yields exactly one new `trig`.
- Reset mid-debounce: `rst` at edge 2 of a held press → no pulse during reset. After release of `rst`, one `trig` arrives exactly 6 edges later.
